frame_counter: RTL and testbench

FRAME_COUNTER -- requirements
Module: frame_counter

---
 rtl/frame_counter.sv | 100 ++++++++++
 tb/tb_frame_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_counter.sv
// Frame counter: counts 0..max_q in RUN, one-shot or free-running.
// Latency: start accepted at the edge it is seen; count/overflow/done are registered.
// No backpressure; stop aborts the run; optional preset via FRAME_COUNTER_LOAD_EN macro.
module frame_counter #(
  parameter int WIDTH        = 5,
  parameter int AUTO_RESTART = 0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] max_count,
`ifdef FRAME_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             overflow,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] max_q;
  logic             overflow_q;
  logic             done_q;
  logic             terminal_d;

  // Terminal count is reached when the running count matches the captured limit.
  assign terminal_d = (count_q == max_q);

`ifdef FRAME_COUNTER_LOAD_EN
  logic [WIDTH-1:0] load_sat_d;

  // A preset never lands beyond the terminal count.
  assign load_sat_d = (load_value > max_q) ? max_q : load_value;
`endif

  // Control FSM with registered count, limit and pulse outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      count_q    <= '0;
      max_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= '0;
          // stop has priority over start; stop alone in IDLE is a no-op.
          if (start && !stop) begin
            state_q <= RUN;
            max_q   <= max_count;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort overrides terminal count and preset; no pulses.
            state_q <= IDLE;
            count_q <= '0;
          end else if (terminal_d) begin
            count_q    <= '0;
            overflow_q <= 1'b1;
            if (AUTO_RESTART == 0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
`ifdef FRAME_COUNTER_LOAD_EN
          else if (load) begin
            count_q <= load_sat_d;
          end
`endif
          else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign count    = count_q;
  assign busy     = (state_q == RUN);
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_frame_counter.sv
// Bench for frame_counter: one-shot and free-running instances share stimulus.
// A behavioural model is compared every cycle; directed literal checks pin the model.
// Random phase mixes start/stop/limit changes and asynchronous resets.
module tb_frame_counter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] max_count = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;

  logic [W-1:0] count0, count1;
  logic         busy0, busy1, ov0, ov1, done0, done1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state per instance: 0 = one-shot, 1 = free-running.
  int mcnt[2];
  int mmax[2];
  bit mrun[2];
  bit mov[2];
  bit mdone[2];

  always #5 clk = ~clk;

  frame_counter #(.WIDTH(W), .AUTO_RESTART(0)) dut0 (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop), .max_count(max_count),
`ifdef FRAME_COUNTER_LOAD_EN
    .load(load), .load_value(load_value),
`endif
    .count(count0), .busy(busy0), .overflow(ov0), .done(done0)
  );

  frame_counter #(.WIDTH(W), .AUTO_RESTART(1)) dut1 (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop), .max_count(max_count),
`ifdef FRAME_COUNTER_LOAD_EN
    .load(load), .load_value(load_value),
`endif
    .count(count1), .busy(busy1), .overflow(ov1), .done(done1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what each counter must show after every edge.
  always @(posedge clk or negedge resetN) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetN) begin
        mrun[i] <= 1'b0; mcnt[i] <= 0; mmax[i] <= 0; mov[i] <= 1'b0; mdone[i] <= 1'b0;
      end else if (!mrun[i]) begin
        mov[i] <= 1'b0; mdone[i] <= 1'b0; mcnt[i] <= 0;
        if (start && !stop) begin
          mrun[i] <= 1'b1;
          mmax[i] <= int'(max_count);
        end
      end else if (stop) begin
        mrun[i] <= 1'b0; mcnt[i] <= 0; mov[i] <= 1'b0; mdone[i] <= 1'b0;
      end else if (mcnt[i] == mmax[i]) begin
        mcnt[i]  <= 0;
        mov[i]   <= 1'b1;
        mdone[i] <= (i == 0);
        if (i == 0) mrun[i] <= 1'b0;
      end else begin
        mov[i] <= 1'b0; mdone[i] <= 1'b0;
`ifdef FRAME_COUNTER_LOAD_EN
        if (load)
          mcnt[i] <= (int'(load_value) > mmax[i]) ? mmax[i] : int'(load_value);
        else
          mcnt[i] <= mcnt[i] + 1;
`else
        mcnt[i] <= mcnt[i] + 1;
`endif
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m0_count", int'(count0), mcnt[0]);
      chk("m0_busy", int'(busy0), int'(mrun[0]));
      chk("m0_ovf", int'(ov0), int'(mov[0]));
      chk("m0_done", int'(done0), int'(mdone[0]));
      chk("m1_count", int'(count1), mcnt[1]);
      chk("m1_busy", int'(busy1), int'(mrun[1]));
      chk("m1_ovf", int'(ov1), int'(mov[1]));
      chk("m1_done", int'(done1), int'(mdone[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic kick(input int mc);
    max_count = W'(mc);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", int'(count0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ovf", int'(ov0), 0);
    chk("rst_done", int'(done1), 0);
    resetN = 1'b1;
    cmp_en = 1'b1;

    // One-shot with limit 4: 0,1,2,3,4 then wrap with overflow+done, idle.
    kick(4);
    chk("os_first_count", int'(count0), 0);
    chk("os_first_busy", int'(busy0), 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("os_count", int'(count0), k);
    end
    step();
    chk("os_wrap_count", int'(count0), 0);
    chk("os_wrap_ovf", int'(ov0), 1);
    chk("os_wrap_done", int'(done0), 1);
    chk("os_wrap_busy", int'(busy0), 0);
    chk("fr_wrap_ovf", int'(ov1), 1);
    chk("fr_wrap_done", int'(done1), 0);
    chk("fr_wrap_busy", int'(busy1), 1);
    step();
    chk("os_after_ovf", int'(ov0), 0);
    chk("os_after_busy", int'(busy0), 0);
    go_idle();

    // Free-running with limit 2.
    kick(2);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("fr_count", int'(count1), c % 3);
      chk("fr_ovf", int'(ov1), int'(c % 3 == 0));
      chk("fr_done", int'(done1), 0);
    end
    go_idle();

    // Limit 0 in free-running: count stuck at 0, overflow every cycle.
    kick(0);
    chk("z_count", int'(count1), 0);
    chk("z_ovf_first", int'(ov1), 0);
    repeat (4) begin
      step();
      chk("z_ovf", int'(ov1), 1);
      chk("z_count", int'(count1), 0);
      chk("z_busy", int'(busy1), 1);
    end
    go_idle();

    // Full range, stop exactly at terminal count.
    kick(31);
    repeat (31) step();
    chk("full_count", int'(count0), 31);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_count", int'(count0), 0);
    chk("stop_busy", int'(busy0), 0);
    chk("stop_ovf", int'(ov0), 0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy0", int'(busy0), 0);
    chk("ss_busy1", int'(busy1), 0);

    // Asynchronous reset mid-count.
    kick(20);
    repeat (7) step();
    chk("pre_rst_count", int'(count0), 7);
    resetN = 1'b0;
    #1;
    chk("arst_count", int'(count0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_done", int'(done0), 0);
    step();
    resetN = 1'b1;
    kick(20);
    chk("post_rst_count", int'(count0), 0);
    chk("post_rst_busy", int'(busy0), 1);
    step();
    chk("post_rst_inc", int'(count0), 1);
    go_idle();

`ifdef FRAME_COUNTER_LOAD_EN
    // Preset beyond the limit saturates, then wraps with overflow.
    kick(10);
    repeat (3) step();
    chk("ld_pre", int'(count0), 3);
    load = 1'b1; load_value = W'(20);
    step();
    load = 1'b0;
    chk("ld_count", int'(count0), 10);
    chk("ld_ovf", int'(ov0), 0);
    step();
    chk("ld_wrap_count", int'(count0), 0);
    chk("ld_wrap_ovf", int'(ov0), 1);
    go_idle();
`endif

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) max_count = '0;
      else if (r == 1) max_count = W'(31);
      else max_count = W'($urandom_range(0, 31));
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      load       = ($urandom_range(0, 9) == 0);
      load_value = W'($urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) begin
        #1;
        resetN = 1'b0;
      end
      step();
      resetN = 1'b1;
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
